// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, execution-unit states and default widths.
package alu_pkg;

   localparam int unsigned ALU_WIDTH = 8;
   localparam int unsigned ALU_SEL_W = 4;

   typedef enum logic [3:0] {
      OP_ADD  = 4'h0,
      OP_SUB  = 4'h1,
      OP_MUL  = 4'h2,
      OP_DIV  = 4'h3,
      OP_SHL  = 4'h4,
      OP_SHR  = 4'h5,
      OP_ROL  = 4'h6,
      OP_ROR  = 4'h7,
      OP_AND  = 4'h8,
      OP_OR   = 4'h9,
      OP_XOR  = 4'hA,
      OP_NOR  = 4'hB,
      OP_NAND = 4'hC,
      OP_XNOR = 4'hD,
      OP_GT   = 4'hE,
      OP_EQ   = 4'hF
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE,
      DIV,
      HOLD
   } alu_state_e;

endpackage

// File: rtl/alu_div_seq.sv
// Iterative restoring divider: loads on start, then retires one quotient bit per
// cycle for WIDTH cycles and pulses done with quotient/remainder valid.
module alu_div_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] divisor_q;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   diff;

   // quotient doubles as the dividend shift register; its MSB feeds the partial remainder
   assign trial = {remainder, quotient[WIDTH-1]};
   assign diff  = trial - {1'b0, divisor_q};

   always_ff @(posedge clk) begin
      if (reset) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         divisor_q <= '0;
         cnt       <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            busy      <= 1'b1;
            quotient  <= dividend;
            remainder <= '0;
            divisor_q <= divisor;
            cnt       <= '0;
         end else if (busy) begin
            if (!diff[WIDTH]) begin
               remainder <= diff[WIDTH-1:0];
               quotient  <= {quotient[WIDTH-2:0], 1'b1};
            end else begin
               remainder <= trial[WIDTH-1:0];
               quotient  <= {quotient[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Handshaked ALU execution unit: one request in flight, single-cycle ops except
// divide, which runs on the iterative divider before the result is held for hand-off.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH,
   parameter int unsigned SEL_W = ALU_SEL_W,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [SEL_W-1:0] ALU_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALU_out,
   output logic             Carry_out,
   output logic             div_by_zero,
   output logic [CNT_W-1:0] op_count
);

   alu_state_e state_q, state_d;
   alu_op_e    op;

   logic             accept;
   logic             div_start;
   logic             div_busy;
   logic             div_done;
   logic [WIDTH-1:0] div_quo;
   logic [WIDTH-1:0] div_rem;

   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     dif;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   res_d;
   logic               carry_d;
   logic               dbz_d;

   assign op        = alu_op_e'(ALU_sel);
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == HOLD);
   assign accept    = in_ready && in_valid;
   assign div_start = accept && (op == OP_DIV) && (B != '0);

   alu_div_seq #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .reset     (reset),
      .start     (div_start),
      .dividend  (A),
      .divisor   (B),
      .busy      (div_busy),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (in_valid) state_d = div_start ? DIV : HOLD;
         DIV: begin
            if (div_done)       state_d = HOLD;
            else if (!div_busy) state_d = IDLE;
         end
         HOLD: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign sum  = {1'b0, A} + {1'b0, B};
   assign dif  = {1'b0, A} - {1'b0, B};
   assign prod = A * B;

   always_comb begin
      res_d   = '0;
      carry_d = 1'b0;
      dbz_d   = 1'b0;
      case (op)
         OP_ADD:  begin res_d = sum[WIDTH-1:0]; carry_d = sum[WIDTH]; end
         OP_SUB:  begin res_d = dif[WIDTH-1:0]; carry_d = dif[WIDTH]; end
         OP_MUL:  begin res_d = prod[WIDTH-1:0]; carry_d = |prod[2*WIDTH-1:WIDTH]; end
         OP_DIV:  begin res_d = '1; dbz_d = 1'b1; end
         OP_SHL:  res_d = {A[WIDTH-2:0], 1'b0};
         OP_SHR:  res_d = {1'b0, A[WIDTH-1:1]};
         OP_ROL:  res_d = {A[WIDTH-2:0], A[WIDTH-1]};
         OP_ROR:  res_d = {A[0], A[WIDTH-1:1]};
         OP_AND:  res_d = A & B;
         OP_OR:   res_d = A | B;
         OP_XOR:  res_d = A ^ B;
         OP_NOR:  res_d = ~(A | B);
         OP_NAND: res_d = ~(A & B);
         OP_XNOR: res_d = ~(A ^ B);
         OP_GT:   res_d = {{(WIDTH-1){1'b0}}, (A > B)};
         OP_EQ:   res_d = {{(WIDTH-1){1'b0}}, (A == B)};
         default: res_d = '0;
      endcase
   end

   // OP_DIV only reaches the direct load path when B==0; otherwise the divider supplies it
   always_ff @(posedge clk) begin
      if (reset) begin
         ALU_out     <= '0;
         Carry_out   <= 1'b0;
         div_by_zero <= 1'b0;
         op_count    <= '0;
      end else begin
         if (accept && !div_start) begin
            ALU_out     <= res_d;
            Carry_out   <= carry_d;
            div_by_zero <= dbz_d;
         end else if (state_q == DIV && div_done) begin
            ALU_out     <= div_quo;
            Carry_out   <= |div_rem;
            div_by_zero <= 1'b0;
         end
         if (out_valid && out_ready) op_count <= op_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: vector table driven through a result
// scoreboard, plus backpressure and reset-during-divide sequences.
module tb_alu_exec_unit;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned SEL_W = 4;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned NVEC  = 26;

   logic             clk;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [SEL_W-1:0] ALU_sel;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] ALU_out;
   logic             Carry_out;
   logic             div_by_zero;
   logic [CNT_W-1:0] op_count;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [3:0]  sel;
      logic [7:0]  y;
      logic        c;
      logic        dz;
      int unsigned lat;
   } vec_t;

   typedef struct packed {
      logic [7:0] y;
      logic       c;
      logic       dz;
   } exp_t;

   vec_t        vecs [NVEC];
   exp_t        sb   [$];
   int unsigned checks;
   int unsigned errors;
   int unsigned exp_cnt;

   alu_exec_unit #(.WIDTH(WIDTH), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .A           (A),
      .B           (B),
      .ALU_sel     (ALU_sel),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .ALU_out     (ALU_out),
      .Carry_out   (Carry_out),
      .div_by_zero (div_by_zero),
      .op_count    (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pop_compare(input string name);
      exp_t e;
      if (sb.size() == 0) begin
         chk({name, " scoreboard empty"}, 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      chk({name, " ALU_out"}, {24'd0, ALU_out}, {24'd0, e.y});
      chk({name, " Carry_out"}, {31'd0, Carry_out}, {31'd0, e.c});
      chk({name, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, e.dz});
   endtask

   // Drive one request, wait (bounded) for its result, compare, then hand it off.
   task automatic run_vec(input vec_t v, input int idx);
      int unsigned cyc;
      logic        ready_low;
      string       nm;
      nm = $sformatf("vec%0d sel%0h", idx, v.sel);
      chk({nm, " in_ready before"}, {31'd0, in_ready}, 32'd1);
      A = v.a; B = v.b; ALU_sel = v.sel; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      sb.push_back('{y: v.y, c: v.c, dz: v.dz});
      cyc = 0;
      ready_low = 1'b1;
      while (!out_valid && cyc < 100) begin
         if (in_ready) ready_low = 1'b0;
         step();
         cyc++;
      end
      chk({nm, " latency"}, cyc, v.lat);
      chk({nm, " in_ready low while busy"}, {31'd0, ready_low & ~in_ready}, 32'd1);
      pop_compare(nm);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      exp_cnt++;
      chk({nm, " op_count"}, {16'd0, op_count}, exp_cnt);
      chk({nm, " out_valid after handoff"}, {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      checks = 0; errors = 0; exp_cnt = 0;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      A = '0; B = '0; ALU_sel = '0;

      vecs[0]  = '{8'hF0, 8'h20, 4'h0, 8'h10, 1'b1, 1'b0, 0};
      vecs[1]  = '{8'h05, 8'h07, 4'h1, 8'hFE, 1'b1, 1'b0, 0};
      vecs[2]  = '{8'd100, 8'd7, 4'h3, 8'd14, 1'b1, 1'b0, 9};
      vecs[3]  = '{8'h55, 8'h00, 4'h3, 8'hFF, 1'b0, 1'b1, 0};
      vecs[4]  = '{8'h12, 8'h34, 4'h0, 8'h46, 1'b0, 1'b0, 0};
      vecs[5]  = '{8'h80, 8'h7F, 4'h1, 8'h01, 1'b0, 1'b0, 0};
      vecs[6]  = '{8'h0F, 8'h0F, 4'h2, 8'hE1, 1'b0, 1'b0, 0};
      vecs[7]  = '{8'd84, 8'd4, 4'h3, 8'd21, 1'b0, 1'b0, 9};
      vecs[8]  = '{8'hFF, 8'h01, 4'h3, 8'hFF, 1'b0, 1'b0, 9};
      vecs[9]  = '{8'h03, 8'h0A, 4'h3, 8'h00, 1'b1, 1'b0, 9};
      vecs[10] = '{8'h81, 8'h00, 4'h4, 8'h02, 1'b0, 1'b0, 0};
      vecs[11] = '{8'h81, 8'h00, 4'h5, 8'h40, 1'b0, 1'b0, 0};
      vecs[12] = '{8'h81, 8'h00, 4'h6, 8'h03, 1'b0, 1'b0, 0};
      vecs[13] = '{8'h81, 8'h00, 4'h7, 8'hC0, 1'b0, 1'b0, 0};
      vecs[14] = '{8'hF0, 8'h3C, 4'h8, 8'h30, 1'b0, 1'b0, 0};
      vecs[15] = '{8'hF0, 8'h3C, 4'h9, 8'hFC, 1'b0, 1'b0, 0};
      vecs[16] = '{8'hF0, 8'h3C, 4'hA, 8'hCC, 1'b0, 1'b0, 0};
      vecs[17] = '{8'hF0, 8'h3C, 4'hB, 8'h03, 1'b0, 1'b0, 0};
      vecs[18] = '{8'hF0, 8'h3C, 4'hC, 8'hCF, 1'b0, 1'b0, 0};
      vecs[19] = '{8'hF0, 8'h3C, 4'hD, 8'h33, 1'b0, 1'b0, 0};
      vecs[20] = '{8'h05, 8'h03, 4'hE, 8'h01, 1'b0, 1'b0, 0};
      vecs[21] = '{8'h03, 8'h03, 4'hE, 8'h00, 1'b0, 1'b0, 0};
      vecs[22] = '{8'h03, 8'h03, 4'hF, 8'h01, 1'b0, 1'b0, 0};
      vecs[23] = '{8'h03, 8'h04, 4'hF, 8'h00, 1'b0, 1'b0, 0};
      vecs[24] = '{8'hFF, 8'h01, 4'h0, 8'h00, 1'b1, 1'b0, 0};
      vecs[25] = '{8'h10, 8'h10, 4'h2, 8'h00, 1'b1, 1'b0, 0};

      step();
      step();
      reset = 1'b0;
      chk("reset in_ready", {31'd0, in_ready}, 32'd1);
      chk("reset out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset ALU_out", {24'd0, ALU_out}, 32'd0);
      chk("reset Carry_out", {31'd0, Carry_out}, 32'd0);
      chk("reset div_by_zero", {31'd0, div_by_zero}, 32'd0);
      chk("reset op_count", {16'd0, op_count}, 32'd0);

      // Reset during a divide: the result must never appear.
      begin
         logic seen;
         A = 8'd100; B = 8'd7; ALU_sel = 4'h3; in_valid = 1'b1;
         step();
         in_valid = 1'b0;
         repeat (3) step();
         chk("abort in_ready mid-divide", {31'd0, in_ready}, 32'd0);
         reset = 1'b1;
         step();
         reset = 1'b0;
         chk("abort out_valid", {31'd0, out_valid}, 32'd0);
         chk("abort in_ready", {31'd0, in_ready}, 32'd1);
         chk("abort op_count", {16'd0, op_count}, 32'd0);
         seen = 1'b0;
         repeat (WIDTH + 4) begin
            if (out_valid) seen = 1'b1;
            step();
         end
         chk("abort no late out_valid", {31'd0, seen}, 32'd0);
      end

      for (int i = 0; i < int'(NVEC); i++) run_vec(vecs[i], i);

      // Backpressure: result held while the consumer stalls; requests during HOLD ignored.
      A = 8'h10; B = 8'h10; ALU_sel = 4'h2; in_valid = 1'b1;
      step();
      sb.push_back('{y: 8'h00, c: 1'b1, dz: 1'b0});
      chk("bp out_valid", {31'd0, out_valid}, 32'd1);
      for (int k = 0; k < 5; k++) begin
         A = 8'h01 + 8'(k); B = 8'h02; ALU_sel = 4'h0; in_valid = 1'b1;
         chk($sformatf("bp hold%0d ALU_out", k), {24'd0, ALU_out}, 32'h00);
         chk($sformatf("bp hold%0d Carry_out", k), {31'd0, Carry_out}, 32'd1);
         chk($sformatf("bp hold%0d in_ready", k), {31'd0, in_ready}, 32'd0);
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("bp in_ready low with out_ready", {31'd0, in_ready}, 32'd0);
      pop_compare("bp");
      step();
      out_ready = 1'b0;
      exp_cnt++;
      chk("bp op_count", {16'd0, op_count}, exp_cnt);
      chk("bp in_ready after", {31'd0, in_ready}, 32'd1);
      step();
      chk("bp no extra result", {31'd0, out_valid}, 32'd0);
      chk("bp op_count stable", {16'd0, op_count}, exp_cnt);
      chk("scoreboard drained", sb.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
